// File: rtl/alu_cmd_issuer.sv
// Command front end for pipeline_alu: credit-gated issue, in-order result return
// with optional expected-value compare, and a valid/ready response stream.
module alu_cmd_issuer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_a,
  input  logic [WIDTH-1:0] i_cmd_b,
  input  logic [2:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_exp,
  input  logic             i_cmd_chk,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [2:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  input  logic             i_alu_cf,
  input  logic             i_alu_valid,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_zero,
  output logic             o_rsp_cf,
  output logic             o_rsp_mismatch,
  output logic [15:0]      o_err_count,
  output logic             o_proto_err,
  output logic             o_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = AW + 2;
  localparam int EW = WIDTH + 1;
  localparam int RW = WIDTH + 3;

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  logic [WIDTH-1:0] alu_a_p0;
  logic [WIDTH-1:0] alu_b_p0;
  logic [2:0]       alu_op_p0;
  logic             alu_vld_p0;

  logic [PW-1:0]    inflight;
  logic [PW-1:0]    exp_wr;
  logic [PW-1:0]    exp_rd;
  logic [EW-1:0]    exp_mem [DEPTH];
  logic [PW-1:0]    rsp_wr;
  logic [PW-1:0]    rsp_rd;
  logic [RW-1:0]    rsp_mem [DEPTH];
  logic [15:0]      err_cnt;
  logic             proto_err;

  logic [PW-1:0]    rsp_count;
  logic [CW-1:0]    credit_used;
  logic             rsp_empty;
  logic             accept;
  logic             ret;
  logic             drop;
  logic             rsp_pop;
  logic [WIDTH-1:0] head_exp;
  logic             head_chk;
  logic             mismatch;
  logic [RW-1:0]    rsp_head;

  // Credit accounting: every in-flight result already owns a response slot.
  assign rsp_count   = rsp_wr - rsp_rd;
  assign credit_used = {1'b0, inflight} + {1'b0, rsp_count};
  assign o_cmd_ready = (credit_used < CW'(DEPTH));
  assign rsp_empty   = (rsp_wr == rsp_rd);
  assign accept      = i_cmd_valid & o_cmd_ready;
  assign ret         = i_alu_valid & (inflight != '0);
  assign drop        = i_alu_valid & (inflight == '0);
  assign rsp_pop     = o_rsp_valid & i_rsp_ready;

  assign {head_exp, head_chk} = exp_mem[exp_rd[AW-1:0]];
  assign mismatch = head_chk & (i_alu_result != head_exp);

  // Issue stage: one registered ALU beat per accepted command.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_a_p0   <= '0;
      alu_b_p0   <= '0;
      alu_op_p0  <= '0;
      alu_vld_p0 <= 1'b0;
    end else begin
      alu_vld_p0 <= accept;
      if (accept) begin
        alu_a_p0  <= i_cmd_a;
        alu_b_p0  <= i_cmd_b;
        alu_op_p0 <= i_cmd_op;
      end
    end
  end

  assign o_alu_a     = alu_a_p0;
  assign o_alu_b     = alu_b_p0;
  assign o_alu_op    = alu_op_p0;
  assign o_alu_valid = alu_vld_p0;

  // Expect FIFO: occupancy always equals inflight, so it cannot overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_wr <= '0;
      exp_rd <= '0;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] <= '0;
    end else begin
      if (accept) begin
        exp_mem[exp_wr[AW-1:0]] <= {i_cmd_exp, i_cmd_chk};
        exp_wr <= exp_wr + PW'(1);
      end
      if (ret) exp_rd <= exp_rd + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, ret})
        2'b10:   inflight <= inflight + PW'(1);
        2'b01:   inflight <= inflight - PW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Return stage: capture ALU result with its compare outcome.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_wr <= '0;
      rsp_rd <= '0;
      for (int i = 0; i < DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (ret) begin
        rsp_mem[rsp_wr[AW-1:0]] <= {i_alu_result, i_alu_zero, i_alu_cf, mismatch};
        rsp_wr <= rsp_wr + PW'(1);
      end
      if (rsp_pop) rsp_rd <= rsp_rd + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (ret && mismatch) err_cnt <= sat_inc(err_cnt);
      if (drop) proto_err <= 1'b1;
    end
  end

  assign rsp_head    = rsp_mem[rsp_rd[AW-1:0]];
  assign o_rsp_valid = ~rsp_empty;
  assign {o_rsp_result, o_rsp_zero, o_rsp_cf, o_rsp_mismatch} = rsp_head;
  assign o_err_count = err_cnt;
  assign o_proto_err = proto_err;
  assign o_busy      = (inflight != '0) | ~rsp_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a one-stage behavioural ALU model.
module tb_alu_cmd_issuer;

  localparam logic [2:0] OP_SUM = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  logic        t_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [7:0]  i_cmd_a = '0;
  logic [7:0]  i_cmd_b = '0;
  logic [2:0]  i_cmd_op = '0;
  logic [7:0]  i_cmd_exp = '0;
  logic        i_cmd_chk = 1'b0;
  logic [7:0]  o_alu_a;
  logic [7:0]  o_alu_b;
  logic [2:0]  o_alu_op;
  logic        o_alu_valid;
  logic [7:0]  i_alu_result;
  logic        i_alu_zero;
  logic        i_alu_cf;
  logic        i_alu_valid;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [7:0]  o_rsp_result;
  logic        o_rsp_zero;
  logic        o_rsp_cf;
  logic        o_rsp_mismatch;
  logic [15:0] o_err_count;
  logic        o_proto_err;
  logic        o_busy;

  logic        m_v = 1'b0;
  logic [7:0]  m_r = '0;
  logic        m_z = 1'b0;
  logic        m_c = 1'b0;
  logic        force_v = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  logic [11:0] rq[$];

  always #5 t_clk = ~t_clk;

  alu_cmd_issuer #(.WIDTH(8), .DEPTH(4)) dut (
    .i_clk(t_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .i_cmd_op(i_cmd_op),
    .i_cmd_exp(i_cmd_exp), .i_cmd_chk(i_cmd_chk),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid),
    .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_cf(i_alu_cf),
    .i_alu_valid(i_alu_valid),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_result(o_rsp_result), .o_rsp_zero(o_rsp_zero), .o_rsp_cf(o_rsp_cf),
    .o_rsp_mismatch(o_rsp_mismatch), .o_err_count(o_err_count),
    .o_proto_err(o_proto_err), .o_busy(o_busy)
  );

  // Behavioural ALU: one register stage, no reset, no backpressure.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    logic [8:0] w;
    case (op)
      OP_SUM:  w = {1'b0, a} + {1'b0, b};
      OP_SUB:  w = {1'b0, a} - {1'b0, b};
      OP_AND:  w = {1'b0, a & b};
      OP_OR:   w = {1'b0, a | b};
      OP_XOR:  w = {1'b0, a ^ b};
      default: w = '0;
    endcase
    return {(w[7:0] == 8'h00), w[8], w[7:0]};
  endfunction

  always @(posedge t_clk) begin
    m_v <= o_alu_valid;
    {m_z, m_c, m_r} <= alu_f(o_alu_a, o_alu_b, o_alu_op);
  end

  assign i_alu_valid  = m_v | force_v;
  assign i_alu_result = m_r;
  assign i_alu_zero   = m_z;
  assign i_alu_cf     = m_c;

  // Record each response at the negedge before the edge that pops it.
  always @(negedge t_clk)
    if (i_rst_n && o_rsp_valid && i_rsp_ready)
      rq.push_back({o_busy, o_rsp_result, o_rsp_zero, o_rsp_cf, o_rsp_mismatch});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge t_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [7:0] exp, input logic chk);
    logic acc;
    int t;
    i_cmd_a = a; i_cmd_b = b; i_cmd_op = op; i_cmd_exp = exp; i_cmd_chk = chk;
    i_cmd_valid = 1'b1;
    acc = 1'b0;
    t = 0;
    while (!acc && t < 50) begin
      acc = o_cmd_ready;
      step();
      t++;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int t = 0;
    while (rq.size() < n && t < 100) begin
      step();
      t++;
    end
    check(tag, rq.size(), n);
  endtask

  task automatic check_rsp(input string tag, input logic [7:0] res, input logic zero,
                           input logic mm);
    logic [11:0] e;
    e = (rq.size() > 0) ? rq.pop_front() : 12'hxxx;
    check({tag, "_result"}, e[10:3], res);
    check({tag, "_zero"}, e[2], zero);
    check({tag, "_mismatch"}, e[0], mm);
  endtask

  initial begin
    int k;
    logic acc;
    logic [11:0] e;

    // Reset state
    #2;
    check("rst_alu_valid", o_alu_valid, 0);
    check("rst_alu_a", o_alu_a, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_err_count", o_err_count, 0);
    check("rst_proto_err", o_proto_err, 0);
    check("rst_busy", o_busy, 0);
    step(); step();
    i_rst_n = 1'b1;
    #1;
    check("rst_cmd_ready", o_cmd_ready, 1);

    // Single checked XOR
    send(8'h3C, 8'h03, OP_XOR, 8'h3F, 1'b1);
    i_cmd_valid = 1'b0;
    check("xor_alu_valid", o_alu_valid, 1);
    check("xor_alu_a", o_alu_a, 8'h3C);
    check("xor_alu_b", o_alu_b, 8'h03);
    check("xor_alu_op", o_alu_op, OP_XOR);
    step();
    check("xor_alu_pulse_end", o_alu_valid, 0);
    wait_rsp("xor_rsp_count", 1);
    check_rsp("xor", 8'h3F, 1'b0, 1'b0);
    check("xor_err_count", o_err_count, 0);

    // Back-to-back stream
    send(8'd2, 8'd2, OP_SUM, 8'd4, 1'b1);
    check("b2b_valid0", o_alu_valid, 1);
    send(8'h3C, 8'h04, OP_AND, 8'h04, 1'b1);
    check("b2b_valid1", o_alu_valid, 1);
    send(8'd7, 8'd2, OP_SUB, 8'd5, 1'b1);
    check("b2b_valid2", o_alu_valid, 1);
    i_cmd_valid = 1'b0;
    wait_rsp("b2b_rsp_count", 3);
    check_rsp("b2b0", 8'd4, 1'b0, 1'b0);
    check_rsp("b2b1", 8'h04, 1'b0, 1'b0);
    check_rsp("b2b2", 8'd5, 1'b0, 1'b0);

    // Zero flag and mismatch accounting
    send(8'd5, 8'd5, OP_SUB, 8'd0, 1'b1);
    i_cmd_valid = 1'b0;
    wait_rsp("zero_rsp_count", 1);
    check_rsp("zero", 8'd0, 1'b1, 1'b0);
    send(8'd2, 8'd2, OP_SUM, 8'd5, 1'b1);
    i_cmd_valid = 1'b0;
    wait_rsp("mm_rsp_count", 1);
    check_rsp("mm", 8'd4, 1'b0, 1'b1);
    check("mm_err_count", o_err_count, 1);
    send(8'd2, 8'd2, OP_SUM, 8'd5, 1'b0);
    i_cmd_valid = 1'b0;
    wait_rsp("nochk_rsp_count", 1);
    check_rsp("nochk", 8'd4, 1'b0, 1'b0);
    check("nochk_err_count", o_err_count, 1);

    // Backpressure: consumer stalled, six commands offered
    i_rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 6) begin
        i_cmd_a = 8'(k); i_cmd_b = 8'd10; i_cmd_op = OP_SUM;
        i_cmd_exp = 8'(10 + k); i_cmd_chk = 1'b1; i_cmd_valid = 1'b1;
      end else begin
        i_cmd_valid = 1'b0;
      end
      acc = i_cmd_valid & o_cmd_ready;
      step();
      if (acc) k++;
    end
    check("bp_accepted", k, 4);
    check("bp_cmd_ready", o_cmd_ready, 0);
    check("bp_rsp_valid", o_rsp_valid, 1);
    check("bp_busy", o_busy, 1);
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      i_cmd_a = 8'(k); i_cmd_b = 8'd10; i_cmd_op = OP_SUM;
      i_cmd_exp = 8'(10 + k); i_cmd_chk = 1'b1; i_cmd_valid = 1'b1;
      acc = o_cmd_ready;
      step();
      if (acc) k++;
    end
    i_cmd_valid = 1'b0;
    check("bp_accepted_all", k, 6);
    wait_rsp("bp_rsp_count", 6);
    for (int i = 0; i < 6; i++) begin
      e = (rq.size() > 0) ? rq.pop_front() : 12'hxxx;
      check($sformatf("bp%0d_result", i), e[10:3], 8'(10 + i));
      check($sformatf("bp%0d_mismatch", i), e[0], 0);
      if (i == 5) check("bp_busy_before_last_pop", e[11], 1);
    end
    check("bp_busy_after_drain", o_busy, 0);
    check("bp_err_count", o_err_count, 1);

    // Unexpected ALU result while idle
    force_v = 1'b1;
    step();
    force_v = 1'b0;
    check("proto_set", o_proto_err, 1);
    check("proto_no_rsp", o_rsp_valid, 0);
    check("proto_busy", o_busy, 0);
    check("proto_err_count", o_err_count, 1);
    step(); step();
    check("proto_no_rsp_queued", rq.size(), 0);

    // Short reset with a result already leaving the ALU
    send(8'h3C, 8'h03, OP_XOR, 8'h3F, 1'b1);
    i_cmd_valid = 1'b0;
    step();
    i_rst_n = 1'b0;
    #1;
    check("srst_proto_clear", o_proto_err, 0);
    check("srst_busy", o_busy, 0);
    check("srst_err_count", o_err_count, 0);
    i_rst_n = 1'b1;
    step();
    check("srst_stale_proto", o_proto_err, 1);
    check("srst_stale_no_rsp", o_rsp_valid, 0);

    // Reset with two commands in flight
    send(8'd1, 8'd1, OP_SUM, 8'd2, 1'b1);
    send(8'd3, 8'd1, OP_OR, 8'd3, 1'b1);
    i_cmd_valid = 1'b0;
    check("lrst_busy_before", o_busy, 1);
    i_rst_n = 1'b0;
    #1;
    check("lrst_alu_valid", o_alu_valid, 0);
    check("lrst_alu_a", o_alu_a, 0);
    check("lrst_alu_op", o_alu_op, 0);
    check("lrst_rsp_valid", o_rsp_valid, 0);
    check("lrst_proto_err", o_proto_err, 0);
    check("lrst_busy", o_busy, 0);
    step(); step(); step();
    i_rst_n = 1'b1;
    #1;
    check("lrst_cmd_ready", o_cmd_ready, 1);
    step(); step();
    check("lrst_proto_after", o_proto_err, 0);
    check("lrst_no_rsp", rq.size(), 0);

    // Normal operation resumes after reset
    send(8'h3C, 8'h03, OP_XOR, 8'h3F, 1'b1);
    i_cmd_valid = 1'b0;
    wait_rsp("post_rsp_count", 1);
    check_rsp("post", 8'h3F, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
